btn_event_gen: RTL and testbench
================================

// Module: btn_event_gen
// PURPOSE
//  Conditions the raw Genius push-buttons into clean, one-per-press events for the game FSM.
//  Each button gets a 2-flop synchronizer, a debounce filter and press-edge detection.
//  Presses are encoded in the same 2-bit number code the sequence ROM uses (0..2).
//  Events sit in a 1-entry valid/ready buffer; the game FSM consumes one press per handshake instead of sampling button levels.
// PARAMETERS
//  N_BTN            3       number of buttons (max 4 with 2-bit code)
//  DEBOUNCE_CYCLES  500000  cycles a synchronized level must stay stable to be accepted (10 ms @ 50 MHz); >=2
//  BTN_ACTIVE_LOW   1       1: raw pad reads 0 when pressed (inverted after sync); 0: active-high
// PORTS
//  clock          in   1      system clock
//  reset          in   1      asynchronous, active-low reset
//  btn_raw        in   N_BTN  raw, unsynchronized button pads
//  enable         in   1      1: new presses may be loaded into the buffer
//  press_ready    in   1      consumer accepts the event this cycle
//  clear_overrun  in   1      synchronous clear of overrun
//  press_valid    out  1      event pending
//  press_code     out  2      binary index of pressed button (btn_raw[i] -> i)
//  press_onehot   out  N_BTN  one-hot of the same button
//  btn_level      out  N_BTN  debounced, active-high level of each button
//  overrun        out  1      sticky: at least one press was dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops, stable levels, counters 0.
//    press_valid=0, press_code=0, press_onehot=0, btn_level=0, overrun=0.
//  - Synchronizer: two flops per bit, then polarity fix per BTN_ACTIVE_LOW.
//  - Debounce per button: counter cleared whenever sync==stable.
//    While they differ it increments; when it equals DEBOUNCE_CYCLES-1 with mismatch, stable<=sync and counter clears.
//    Counter width $clog2(DEBOUNCE_CYCLES); it never wraps.
//  - Press = stable 0->1. Releases generate no event.
//  - Latency: press_valid rises exactly DEBOUNCE_CYCLES+2 edges after the first edge sampling the new raw level.
//  - Buffer FSM, states EMPTY/FULL:
//    EMPTY: press && enable -> load code/onehot, go FULL.
//    FULL: press_valid=1; code/onehot held stable until press_valid && press_ready.
//    On that handshake: go EMPTY, or reload in the same cycle if a press && enable is present (back-to-back, no bubble).
//  - Simultaneous presses in one cycle: lowest index wins; others dropped, overrun<=1.
//  - Press while FULL and not accepted that cycle: dropped, overrun<=1.
//  - Press while enable=0: discarded silently (no overrun); a pending event is kept.
//    Debouncers and btn_level keep running.
//  - clear_overrun and a new overrun in the same cycle: overrun stays 1 (set wins).
//  - Reset mid-debounce or while FULL: pending event lost; a button still held after reset release is seen as a press once debounced.
// CONFIGURATION
//  BTN_EVT_LOCKOUT_EN defined: after a press is loaded, all further presses are ignored until every btn_level is 0.
//    Ignored presses do not set overrun (anti-chording).
//  Undefined: each button generates events independently per the rules above.
// STRUCTURE
//  genius_pkg: BTN_CODE_W=2 and the number codes NUM_ZERO/NUM_ONE/NUM_TWO shared with the sequence ROM and verifier.
//  Sub-module btn_debouncer (sync + filter + edge, one per button via generate).
//  Buffer FSM and priority encode live in btn_event_gen.
// TESTING (DEBOUNCE_CYCLES=8, BTN_ACTIVE_LOW=1)
//  1. Release reset, hold btn_raw[1]=0 (pressed) steadily.
//     press_valid=1 exactly 10 edges later, code=1, onehot=010. ready=1 clears it; no second event while held.
//  2. Toggle btn_raw[2] every 3 cycles for 40 cycles, then release (idle high).
//     No event ever; btn_level[2] stays 0.
//  3. With ready=0, press btn0 then, after debounce, btn2.
//     Event code=0 held; overrun=1. clear_overrun -> 0.
//  4. Press btn0 and btn2 on the same edge.
//     Single event code=0, overrun=1. With BTN_EVT_LOCKOUT_EN: overrun=0, and no event until all released.
//  5. enable=0, press btn1.
//     No event, btn_level[1]=1. Raise enable while still held: no event (edge already consumed).
//  6. Assert reset while FULL mid-debounce of another button.
//     All outputs 0 immediately (async); after release, the held button yields one event after 10 edges.

Source files
------------

// File: rtl/genius_pkg.sv
// ---------------------------------------------------------------------------
// genius_pkg
// Shared definitions for the Genius game datapath: the 2-bit number code used
// by the sequence ROM, the verifier and the button event generator, plus the
// state type of the one-entry press buffer.
// No ports (package).
// ---------------------------------------------------------------------------
package genius_pkg;

    localparam int BTN_CODE_W = 2;

    localparam logic [BTN_CODE_W-1:0] NUM_ZERO = 2'd0;
    localparam logic [BTN_CODE_W-1:0] NUM_ONE  = 2'd1;
    localparam logic [BTN_CODE_W-1:0] NUM_TWO  = 2'd2;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Button index to the number code the sequence ROM stores.
    function automatic logic [BTN_CODE_W-1:0] index_to_code(input int idx);
        case (idx)
            0:       return NUM_ZERO;
            1:       return NUM_ONE;
            2:       return NUM_TWO;
            default: return BTN_CODE_W'(idx);
        endcase
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer
// One button: 2-flop synchronizer, stability filter and press-edge detect.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous, active-low reset
//   btn_raw  in   raw, unsynchronized pad
//   level    out  debounced, active-high button level
//   press    out  one-cycle pulse, high in the cycle the level is about to
//                 go 0->1 (coincides with the edge that updates level)
// ---------------------------------------------------------------------------
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic             pad_active;
    logic             sync_1;
    logic             sync_2;
    logic             stable_q;
    logic [CNT_W-1:0] count_q;
    logic             settle;

    // The polarity fix is a constant inversion, so it is applied ahead of the
    // synchronizer; that way a reset value of 0 in the flops means "released"
    // and no phantom transition is seen after reset.
    assign pad_active = btn_raw ^ POL;

    // Two-flop synchronizer for the asynchronous pad.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pad_active;
            sync_2 <= sync_1;
        end
    end

    assign settle = (sync_2 != stable_q) && (count_q == CNT_LAST);

    // Stability filter: the counter only runs while the synchronized level
    // disagrees with the accepted one and is cleared on any agreement, so a
    // bounce restarts the wait. It never passes CNT_LAST, so it cannot wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_q <= 1'b0;
            count_q  <= '0;
        end else if (sync_2 == stable_q) begin
            count_q <= '0;
        end else if (settle) begin
            stable_q <= sync_2;
            count_q  <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign level = stable_q;
    assign press = settle & sync_2;

endmodule

// File: rtl/btn_event_gen.sv
// ---------------------------------------------------------------------------
// btn_event_gen
// Turns the raw Genius push-buttons into one event per press, buffered in a
// single-entry valid/ready slot for the game FSM.
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-low reset
//   btn_raw        in   raw button pads [N_BTN]
//   enable         in   new presses may be loaded
//   press_ready    in   consumer takes the pending event this cycle
//   clear_overrun  in   synchronous clear of overrun
//   press_valid    out  event pending
//   press_code     out  number code of the pressed button
//   press_onehot   out  one-hot of the pressed button [N_BTN]
//   btn_level      out  debounced active-high levels [N_BTN]
//   overrun        out  sticky: a press was dropped
// Build option: define BTN_EVT_LOCKOUT_EN to ignore all presses after a
// loaded one until every button is released (anti-chording, no overrun).
// ---------------------------------------------------------------------------
module btn_event_gen
    import genius_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_BTN-1:0]      btn_raw,
    input  logic                  enable,
    input  logic                  press_ready,
    input  logic                  clear_overrun,
    output logic                  press_valid,
    output logic [BTN_CODE_W-1:0] press_code,
    output logic [N_BTN-1:0]      press_onehot,
    output logic [N_BTN-1:0]      btn_level,
    output logic                  overrun
);

    buf_state_t            state_q;
    buf_state_t            state_d;
    logic [N_BTN-1:0]      press_vec;
    logic [N_BTN-1:0]      eff_press;
    logic                  multi;
    logic                  chord_drop;
    logic                  load;
    logic                  ovr_set;
    logic [BTN_CODE_W-1:0] first_code;
    logic [N_BTN-1:0]      first_onehot;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW)
        ) u_deb (
            .clock  (clock),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .level  (btn_level[i]),
            .press  (press_vec[i])
        );
    end

    assign multi = |(eff_press & (eff_press - N_BTN'(1)));

`ifdef BTN_EVT_LOCKOUT_EN
    logic lock_q;

    // Lockout arms on every load and disarms only once all buttons read
    // released; presses seen in between are simply ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
        end else if (load) begin
            lock_q <= 1'b1;
        end else if (btn_level == '0) begin
            lock_q <= 1'b0;
        end
    end

    assign eff_press  = lock_q ? '0 : press_vec;
    assign chord_drop = 1'b0;
`else
    assign eff_press  = press_vec;
    assign chord_drop = multi;
`endif

    // Priority encode: scanning downward leaves the lowest pressed index.
    always_comb begin
        first_code   = '0;
        first_onehot = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (eff_press[i]) begin
                first_code   = index_to_code(i);
                first_onehot = N_BTN'(1) << i;
            end
        end
    end

    // Buffer FSM next state. A handshake frees the slot in the same cycle,
    // so a press arriving with the handshake reloads without a bubble.
    // enable gates presses before any overrun decision, so presses while
    // disabled vanish silently.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        if (state_q == BUF_FULL && press_ready) begin
            state_d = BUF_EMPTY;
        end
        if (enable && (eff_press != '0)) begin
            if (state_q == BUF_EMPTY || press_ready) begin
                load    = 1'b1;
                state_d = BUF_FULL;
                ovr_set = chord_drop;
            end else begin
                ovr_set = 1'b1;
            end
        end
    end

    // State, held event payload and the sticky overrun flag; a new drop
    // outranks a clear in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= BUF_EMPTY;
            press_code   <= '0;
            press_onehot <= '0;
            overrun      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                press_code   <= first_code;
                press_onehot <= first_onehot;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign press_valid = (state_q == BUF_FULL);

endmodule

// File: tb/tb_btn_event_gen.sv
// ---------------------------------------------------------------------------
// tb_btn_event_gen
// Self-checking bench for btn_event_gen (N_BTN=3, DEBOUNCE_CYCLES=8,
// active-low pads): directed scenarios plus a randomized run, all compared
// cycle by cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_btn_event_gen;

    localparam int N_BTN = 3;
    localparam int DEB   = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [N_BTN-1:0] btn_raw = '1;
    logic             enable = 1'b1;
    logic             press_ready = 1'b0;
    logic             clear_overrun = 1'b0;
    logic             press_valid;
    logic [1:0]       press_code;
    logic [N_BTN-1:0] press_onehot;
    logic [N_BTN-1:0] btn_level;
    logic             overrun;

    int check_count = 0;
    int pass_count  = 0;

    // Behavioural model: pads delayed two cycles, a run-length of
    // disagreeing cycles per button, and a single pending-event slot.
    bit [N_BTN-1:0] m_s1, m_s2, m_stable;
    int             m_run [N_BTN];
    bit             m_valid;
    int             m_code;
    bit             m_ovr;
    bit             m_lock;

    btn_event_gen #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .enable       (enable),
        .press_ready  (press_ready),
        .clear_overrun(clear_overrun),
        .press_valid  (press_valid),
        .press_code   (press_code),
        .press_onehot (press_onehot),
        .btn_level    (btn_level),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0;
        for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
        m_valid = 0; m_code = 0; m_ovr = 0; m_lock = 0;
    endtask

    task automatic model_step(input bit [N_BTN-1:0] raw, input bit en, input bit rdy, input bit clr);
        bit [N_BTN-1:0] p;
        bit was_full;
        bit ovr_set;
        bit loaded;
        int lowest;
        p = '0;
        for (int i = 0; i < N_BTN; i++)
            if (m_s2[i] != m_stable[i] && m_run[i] + 1 == DEB && m_s2[i]) p[i] = 1;
`ifdef BTN_EVT_LOCKOUT_EN
        if (m_lock) p = '0;
`endif
        was_full = m_valid;
        ovr_set  = 0;
        loaded   = 0;
        if (was_full && rdy) m_valid = 0;
        if (en && p != 0) begin
            if (!was_full || rdy) begin
                lowest = 0;
                for (int i = N_BTN - 1; i >= 0; i--) if (p[i]) lowest = i;
                m_valid = 1;
                m_code  = lowest;
                loaded  = 1;
`ifndef BTN_EVT_LOCKOUT_EN
                if ($countones(p) > 1) ovr_set = 1;
`endif
            end else begin
                ovr_set = 1;
            end
        end
        if (loaded) m_lock = 1;
        else if (m_stable == 0) m_lock = 0;
        if (ovr_set) m_ovr = 1;
        else if (clr) m_ovr = 0;
        for (int i = 0; i < N_BTN; i++) begin
            if (m_s2[i] == m_stable[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stable[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = ~raw;
    endtask

    task automatic compare_model();
        checkOutput("valid", press_valid, m_valid);
        checkOutput("level", btn_level, m_stable);
        checkOutput("overrun", overrun, m_ovr);
        if (m_valid) begin
            checkOutput("code", press_code, m_code);
            checkOutput("onehot", press_onehot, 1 << m_code);
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare
    // at the next falling edge.
    task automatic applyStimulus(input logic [N_BTN-1:0] raw, input logic en, input logic rdy, input logic clr);
        btn_raw = raw; enable = en; press_ready = rdy; clear_overrun = clr;
        @(posedge clock);
        model_step(raw, en, rdy, clr);
        @(negedge clock);
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(3'b111, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        bit seen;
        logic [N_BTN-1:0] r;
        model_reset();
        #1;
        checkOutput("rst_valid", press_valid, 0);
        checkOutput("rst_code", press_code, 0);
        checkOutput("rst_onehot", press_onehot, 0);
        checkOutput("rst_level", btn_level, 0);
        checkOutput("rst_overrun", overrun, 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;

        // Held press of button 1 straight after reset release.
        for (int k = 0; k < 9; k++) applyStimulus(3'b101, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_lat9", press_valid, 0);
        applyStimulus(3'b101, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_lat10", press_valid, 1);
        checkOutput("t1_code", press_code, 1);
        checkOutput("t1_onehot", press_onehot, 3'b010);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(3'b101, 1'b1, 1'b1, 1'b0);
            seen |= press_valid;
        end
        checkOutput("t1_no_repeat", seen, 0);
        idle(15);

        // Bouncing button 2 never settles.
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            r = 3'b111;
            r[2] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            applyStimulus(r, 1'b1, 1'b1, 1'b0);
            seen |= press_valid | btn_level[2];
        end
        idle(15);
        checkOutput("t2_no_event", seen, 0);

        // Second press while the slot is full and not taken.
        for (int k = 0; k < 12; k++) applyStimulus(3'b110, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_code0", press_code, 0);
        for (int k = 0; k < 12; k++) applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_held", press_code, 0);
        checkOutput("t3_overrun", overrun, 1);
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b1);
        checkOutput("t3_clear", overrun, 0);
        idle(15);

        // Chord: buttons 0 and 2 on the same edge.
        for (int k = 0; k < 12; k++) applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_valid", press_valid, 1);
        checkOutput("t4_code", press_code, 0);
`ifdef BTN_EVT_LOCKOUT_EN
        checkOutput("t4_overrun", overrun, 0);
`else
        checkOutput("t4_overrun", overrun, 1);
`endif
        applyStimulus(3'b111, 1'b1, 1'b1, 1'b1);
        idle(15);

        // Press while disabled, then enable while still held.
        for (int k = 0; k < 12; k++) applyStimulus(3'b101, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_no_event", press_valid, 0);
        checkOutput("t5_level", btn_level[1], 1);
        for (int k = 0; k < 10; k++) applyStimulus(3'b101, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_late_enable", press_valid, 0);
        idle(15);

        // Reset while full and another button is mid-debounce.
        for (int k = 0; k < 12; k++) applyStimulus(3'b110, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
        btn_raw = 3'b011;
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_valid", press_valid, 0);
        checkOutput("t6_onehot", press_onehot, 0);
        checkOutput("t6_level", btn_level, 0);
        model_reset();
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 9; k++) applyStimulus(3'b011, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_lat9", press_valid, 0);
        applyStimulus(3'b011, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_lat10", press_valid, 1);
        checkOutput("t6_code", press_code, 2);
        idle(15);

        // Randomized run against the model.
        r = 3'b111;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N_BTN; i++)
                if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            applyStimulus(r, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
